// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one registered ready/valid output slot between N
// ready/valid requesters; a grant and an output drain can happen in the same cycle.
module handshake_rr_arbiter #(
    parameter int N     = 3,
    parameter int WIDTH = 4,
    localparam int SRC_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SRC_W-1:0]     out_src
);

    logic               outValid_q, outValid_d;
    logic [WIDTH-1:0]   outData_q,  outData_d;
    logic [SRC_W-1:0]   outSrc_q,   outSrc_d;
    logic [SRC_W-1:0]   ptr_q,      ptr_d;

    logic               loadEn;
    logic               found;
    logic               grant;
    logic [SRC_W-1:0]   winner;
    logic [WIDTH-1:0]   winData;

    // Scan from ptr upward with wrap; the first asserted valid wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N;
            if (!found && in_valid[idx]) begin
                found  = 1'b1;
                winner = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        winData = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == SRC_W'(i)) begin
                winData = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign loadEn = !outValid_q || out_ready;
    assign grant  = RESETN && loadEn && found;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = grant && (winner == SRC_W'(i));
        end
    end

    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSrc_d   = outSrc_q;
        ptr_d      = ptr_q;
        if (grant) begin
            outValid_d = 1'b1;
            outData_d  = winData;
            outSrc_d   = winner;
            ptr_d      = SRC_W'((int'(winner) + 1) % N);
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSrc_q   <= '0;
            ptr_q      <= '0;
        end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSrc_q   <= outSrc_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_src   = outSrc_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a slot-and-pointer reference model.
module tb_handshake_rr_arbiter;

    localparam int N     = 3;
    localparam int WIDTH = 4;
    localparam int SRC_W = 2;

    logic                 CLK = 1'b0;
    logic                 RESETN;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [N*WIDTH-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SRC_W-1:0]     out_src;

    int checks = 0;
    int errors = 0;

    // Reference model: one output slot plus the next-priority requester.
    int mPtr   = 0;
    int mValid = 0;
    int mData  = 0;
    int mSrc   = 0;

    handshake_rr_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_src  (out_src)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, check the combinational and registered outputs
    // against the model, then advance the model across the rising edge.
    task automatic applyStimulus(input logic rstn, input logic [N-1:0] valid,
                                 input logic [N*WIDTH-1:0] data, input logic ready);
        int win;
        int expReady;
        @(negedge CLK);
        RESETN    = rstn;
        in_valid  = valid;
        in_data   = data;
        out_ready = ready;
        #1;
        win = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mPtr + k) % N;
            if (win < 0 && valid[idx]) win = idx;
        end
        expReady = (rstn && (mValid == 0 || ready) && win >= 0) ? (1 << win) : 0;
        checkOutput("in_ready",  32'(in_ready),  32'(expReady));
        checkOutput("out_valid", 32'(out_valid), 32'(mValid));
        checkOutput("out_data",  32'(out_data),  32'(mData));
        checkOutput("out_src",   32'(out_src),   32'(mSrc));
        @(posedge CLK);
        if (!rstn) begin
            mValid = 0; mData = 0; mSrc = 0; mPtr = 0;
        end else if (expReady != 0) begin
            mValid = 1;
            mData  = int'((data >> (win*WIDTH)) & 12'hF);
            mSrc   = win;
            mPtr   = (win + 1) % N;
        end else if (mValid != 0 && ready) begin
            mValid = 0;
        end
        #1;
    endtask

    initial begin
        RESETN = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;

        // Reset with every requester asking
        applyStimulus(1'b0, 3'b111, 12'hCBA, 1'b1);
        applyStimulus(1'b0, 3'b111, 12'hCBA, 1'b1);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);

        // Full contention: grants rotate 0,1,2
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 3'b111, 12'hCBA, 1'b1);
            checkOutput("cont_src",  32'(out_src),  32'(i % 3));
            checkOutput("cont_data", 32'(out_data), 32'(10 + i % 3));
        end
        applyStimulus(1'b1, 3'b000, 12'h000, 1'b1);

        // Single requester streaming 1..5
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 3'b010, 12'(i << WIDTH), 1'b1);
            checkOutput("single_valid", 32'(out_valid), 32'd1);
            checkOutput("single_data",  32'(out_data),  32'(i));
            checkOutput("single_src",   32'(out_src),   32'd1);
        end

        // Backpressure with slot holding 0x7 from src 2
        applyStimulus(1'b1, 3'b100, 12'h700, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 3'b011, 12'h021, 1'b0);
            checkOutput("bp_data", 32'(out_data), 32'h7);
            checkOutput("bp_src",  32'(out_src),  32'd2);
        end
        applyStimulus(1'b1, 3'b011, 12'h021, 1'b1);
        checkOutput("bp_refill_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_refill_src",   32'(out_src),   32'd0);
        applyStimulus(1'b1, 3'b011, 12'h021, 1'b1);
        checkOutput("bp_next_src", 32'(out_src), 32'd1);

        // Wrap-around from ptr 2 with requesters 0 and 1
        applyStimulus(1'b1, 3'b011, 12'h054, 1'b1);
        checkOutput("wrap_first",  32'(out_src), 32'd0);
        applyStimulus(1'b1, 3'b011, 12'h054, 1'b1);
        checkOutput("wrap_second", 32'(out_src), 32'd1);

        // Reset mid-stream under contention
        applyStimulus(1'b1, 3'b111, 12'hCBA, 1'b1);
        applyStimulus(1'b0, 3'b111, 12'hCBA, 1'b1);
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 3'b111, 12'hCBA, 1'b1);
        checkOutput("midrst_first", 32'(out_src), 32'd0);

        // Random traffic, occasional resets and backpressure
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 40) != 0),
                          3'($urandom_range(0, 7)),
                          12'($urandom),
                          ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
